multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle successor to the single-cycle combinational MIPS decoder: a state machine sequencing each instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on instruction- and data-memory hit handshakes. It sits in the datapath between the cache interfaces and the register file/ALU, driving all enables and mux selects. It adds a bounded memory-wait watchdog, a parametrised wait limit and counter width, and optional performance counters.

## Interface
- `WAIT_MAX`, default 255: consecutive no-hit cycles allowed in FETCH/MEM before fault; 0 disables the watchdog.
- `CNT_W`, default 32: width of the performance counters.
- Clock and reset: one clock; reset is synchronous and active-high.
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  synchronous reset, active high.
- `instr`  in  32  instruction word, valid while `ihit`=1.
- `ihit`  in  1  instruction memory done.
- `dhit`  in  1  data memory done.
- `zero`  in  1  ALU zero flag, valid in EXEC.
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.
- `iren`  out  1  instruction read request.
- `ir_en`  out  1  latch `instr` into the internal IR.
- `dren` / `dwen`  out  1 each  data read / write request.
- `reg_wr`  out  1  register file write enable.
- `regdst`  out  2  write register: 0 rt, 1 rd, 2 $31.
- `wsel`  out  2  write data: 0 ALU, 1 memory, 2 PC+4, 3 {imm,16'h0}.
- `alu_op`  out  4  aluop_t.
- `alu_src_imm`  out  1  ALU port B takes the immediate.
- `imm_ext`  out  32  sign- or zero-extended immediate, or shamt.
- `pc_en`  out  1  PC update strobe.
- `pc_sel`  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs (JR).
- `halt`  out  1  sticky halt.
- `fault`  out  1  sticky watchdog fault.
- `cycle_cnt`, `instr_cnt`  out  CNT_W each  performance counters.

## Operation
- All decode is from the internal IR, registered in the FETCH cycle in which `ihit`=1.
- FETCH: `iren`=1. On `ihit`: `ir_en`=1, go to DECODE. Otherwise stay.
- DECODE: one cycle, register read. HALT opcode (0x3F) goes to HALTED and sets `halt`; every other opcode goes to EXEC.
- EXEC:
  - R-type ALU: go to WB.
  - I-type ALU and LUI: go to WB.
  - LW/SW: `alu_op`=ADD, `alu_src_imm`=1, go to MEM.
  - BEQ/BNE: `alu_op`=SUB, `pc_en`=1, `pc_sel`=1 when taken (BEQ&zero or BNE&!zero), else 0; go to FETCH.
  - J: `pc_en`=1, `pc_sel`=2, go to FETCH.
  - JAL: as J, plus `reg_wr`=1, `regdst`=2, `wsel`=2.
  - JR: `pc_en`=1, `pc_sel`=3, go to FETCH.
  - Unknown opcode/funct: NOP. `pc_en`=1, `pc_sel`=0, no write, go to FETCH.
- MEM: `dren` (LW) or `dwen` (SW) is held until `dhit`. LW then goes to WB. SW asserts `pc_en` and `pc_sel`=0 in its `dhit` cycle and goes to FETCH.
- WB: `reg_wr`=1, `pc_en`=1, `pc_sel`=0, go to FETCH.
  - `regdst`=1 for R-type, 0 otherwise.
  - `wsel`=1 for LW, 3 for LUI, 0 otherwise.
- Immediate extension: ANDI/ORI/XORI zero-extend; all other I-types sign-extend; SLL/SRL use {27'b0, shamt}.
- Outputs are combinational from `state` and IR. Every output not listed for a state is 0.
- Watchdog: a wait counter increments on each FETCH cycle with `ihit`=0 and each MEM cycle with `dhit`=0, and clears on a hit or any state change. When it reaches `WAIT_MAX`, set `fault`=1 and `halt`=1 and go to HALTED; the pending request deasserts that cycle.
- HALTED is absorbing. Only `RST` leaves it.

## Timing
- `RST` high: `state`=FETCH, IR=0, `halt`=0, `fault`=0, wait counter and perf counters cleared. Every output is gated to 0 while `RST`=1, including `iren`.
- First cycle after `RST` falls: FETCH with `iren`=1.
- Reset asserted mid-instruction aborts it; no `reg_wr` or `pc_en` fires in that cycle.
- Cycle counts with zero memory wait:
  - R/I-ALU: 4.
  - LW: 5.
  - SW: 4.
  - Branch/jump/NOP: 3.
  - HALT: 2 to HALTED.
- Each no-hit cycle adds one cycle.
- `ihit` and `dhit` are sampled only in FETCH and MEM respectively and are ignored in every other state.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every non-reset cycle until HALTED.
  - `instr_cnt` increments on every `pc_en` and on entry to HALTED via the HALT opcode.
  - Both wrap modulo 2^CNT_W.
- Not defined: both counters are tied to 0 and no counter flops are built.

## Test plan
- RST high 3 cycles with `ihit`=1 → all outputs 0. After release → `state`=0, `iren`=1 in the first cycle.
- `instr`=0x00221821 (ADDU $3,$1,$2), `ihit`=1 → states 0,1,2,4. In cycle 4: `reg_wr`=1, `regdst`=1, `alu_op`=ADD, `pc_en`=1, `pc_sel`=0. In cycles 1–3: `reg_wr`=0.
- LW 0x8C220004 with `dhit` low 3 MEM cycles → MEM lasts 4 cycles with `dren`=1 throughout, `imm_ext`=4. WB then has `wsel`=1 and `regdst`=0. Total 8 cycles.
- BEQ 0x10000004:
  - `zero`=1 → EXEC `pc_en`=1, `pc_sel`=1, back to FETCH at cycle 4.
  - `zero`=0 → `pc_sel`=0.
- `WAIT_MAX`=4, `ihit` held 0 → after 4 FETCH cycles: `fault`=1, `halt`=1, `state`=5, `iren`=0. These hold with `ihit` later 1 until RST.
- With `MC_PERF_CNT_EN`: ADDU, ORI, then HALT 0xFC000000, all zero wait → `instr_cnt`=3, `cycle_cnt`=10, `halt`=1. Counters stay frozen afterwards.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundle between the multicycle controller and the
// datapath (cache handshakes in, enables/mux selects/counters out).
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             ihit;
    logic             dhit;
    logic             zero;
    logic [2:0]       state;
    logic             iren;
    logic             ir_en;
    logic             dren;
    logic             dwen;
    logic             reg_wr;
    logic [1:0]       regdst;
    logic [1:0]       wsel;
    logic [3:0]       alu_op;
    logic             alu_src_imm;
    logic [31:0]      imm_ext;
    logic             pc_en;
    logic [1:0]       pc_sel;
    logic             halt;
    logic             fault;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  instr, ihit, dhit, zero,
        output state, iren, ir_en, dren, dwen, reg_wr, regdst, wsel,
               alu_op, alu_src_imm, imm_ext, pc_en, pc_sel, halt, fault,
               cycle_cnt, instr_cnt
    );

    modport slave (
        output instr, ihit, dhit, zero,
        input  state, iren, ir_en, dren, dwen, reg_wr, regdst, wsel,
               alu_op, alu_src_imm, imm_ext, pc_en, pc_sel, halt, fault,
               cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multicycle sequencer FETCH/DECODE/EXEC/MEM/WB
// with a memory-wait watchdog. Outputs are combinational from state + IR and
// forced to 0 while RST is high.
// Optional: define MC_PERF_CNT_EN to build the cycle/instruction counters.
// ALU op encoding: SLL=0 SRL=1 ADD=2 SUB=3 AND=4 OR=5 XOR=6 NOR=7 SLT=8 SLTU=9.
module multicycle_control #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_HALTED = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
        ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
        ALU_SLT = 4'd8, ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [3:0] {
        C_NOP, C_RALU, C_IALU, C_LUI, C_LW, C_SW, C_BEQ, C_BNE,
        C_J, C_JAL, C_JR, C_HALT
    } iclass_t;

    localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    state_t        state_q;
    // Only opcode and the low half of the instruction drive control; the
    // register fields are consumed directly by the datapath.
    logic [5:0]    ir_op_q;
    logic [15:0]   ir_lo_q;
    logic          halt_q;
    logic          fault_q;
    logic [WW-1:0] wait_q;

    iclass_t     cls;
    aluop_t      dec_alu;
    logic        dec_zext;
    logic        dec_shamt;
    logic        dec_imm;
    logic [31:0] imm_val;
    logic        wd_trip;

    // Instruction class, ALU op and immediate form from the latched IR
    always_comb begin
        cls       = C_NOP;
        dec_alu   = ALU_SLL;
        dec_zext  = 1'b0;
        dec_shamt = 1'b0;
        case (ir_op_q)
            6'h00: begin
                cls = C_RALU;
                case (ir_lo_q[5:0])
                    6'h00: begin dec_alu = ALU_SLL; dec_shamt = 1'b1; end
                    6'h02: begin dec_alu = ALU_SRL; dec_shamt = 1'b1; end
                    6'h08: cls = C_JR;
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h22, 6'h23: dec_alu = ALU_SUB;
                    6'h24: dec_alu = ALU_AND;
                    6'h25: dec_alu = ALU_OR;
                    6'h26: dec_alu = ALU_XOR;
                    6'h27: dec_alu = ALU_NOR;
                    6'h2A: dec_alu = ALU_SLT;
                    6'h2B: dec_alu = ALU_SLTU;
                    default: cls = C_NOP;
                endcase
            end
            6'h08, 6'h09: begin cls = C_IALU; dec_alu = ALU_ADD; end
            6'h0A: begin cls = C_IALU; dec_alu = ALU_SLT; end
            6'h0B: begin cls = C_IALU; dec_alu = ALU_SLTU; end
            6'h0C: begin cls = C_IALU; dec_alu = ALU_AND; dec_zext = 1'b1; end
            6'h0D: begin cls = C_IALU; dec_alu = ALU_OR;  dec_zext = 1'b1; end
            6'h0E: begin cls = C_IALU; dec_alu = ALU_XOR; dec_zext = 1'b1; end
            6'h0F: cls = C_LUI;
            6'h23: begin cls = C_LW; dec_alu = ALU_ADD; end
            6'h2B: begin cls = C_SW; dec_alu = ALU_ADD; end
            6'h04: begin cls = C_BEQ; dec_alu = ALU_SUB; end
            6'h05: begin cls = C_BNE; dec_alu = ALU_SUB; end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            6'h3F: cls = C_HALT;
            default: cls = C_NOP;
        endcase
    end

    // Immediate path is only presented for instructions that consume it
    assign dec_imm = dec_shamt || (cls inside {C_IALU, C_LUI, C_LW, C_SW, C_BEQ, C_BNE});
    assign imm_val = dec_shamt ? {27'b0, ir_lo_q[10:6]} :
                     dec_zext  ? {16'b0, ir_lo_q} :
                                 {{16{ir_lo_q[15]}}, ir_lo_q};

    // Watchdog trips on the WAIT_MAX-th consecutive no-hit cycle
    assign wd_trip = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);

    // Sequencer: state, IR, sticky halt/fault and memory-wait counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            ir_op_q <= '0;
            ir_lo_q <= '0;
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.ihit) begin
                        ir_op_q <= bus.instr[31:26];
                        ir_lo_q <= bus.instr[15:0];
                        state_q <= S_DECODE;
                        wait_q  <= '0;
                    end else if (wd_trip) begin
                        state_q <= S_HALTED;
                        halt_q  <= 1'b1;
                        fault_q <= 1'b1;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (cls == C_HALT) begin
                        state_q <= S_HALTED;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_RALU, C_IALU, C_LUI: state_q <= S_WB;
                        C_LW, C_SW:            state_q <= S_MEM;
                        default:               state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (bus.dhit) begin
                        state_q <= (cls == C_LW) ? S_WB : S_FETCH;
                        wait_q  <= '0;
                    end else if (wd_trip) begin
                        state_q <= S_HALTED;
                        halt_q  <= 1'b1;
                        fault_q <= 1'b1;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_WB:     state_q <= S_FETCH;
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    logic        iren_c, ir_en_c, dren_c, dwen_c, reg_wr_c, src_c, pc_en_c;
    logic [1:0]  regdst_c, wsel_c, pc_sel_c;
    logic [3:0]  alu_c;
    logic [31:0] imm_c;

    // Per-state control decode; anything not set here stays 0
    always_comb begin
        iren_c   = 1'b0;
        ir_en_c  = 1'b0;
        dren_c   = 1'b0;
        dwen_c   = 1'b0;
        reg_wr_c = 1'b0;
        regdst_c = 2'd0;
        wsel_c   = 2'd0;
        alu_c    = 4'd0;
        src_c    = 1'b0;
        imm_c    = 32'd0;
        pc_en_c  = 1'b0;
        pc_sel_c = 2'd0;
        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            alu_c = dec_alu;
            src_c = (cls inside {C_IALU, C_LW, C_SW});
            imm_c = dec_imm ? imm_val : 32'd0;
        end
        case (state_q)
            S_FETCH: begin
                iren_c  = 1'b1;
                ir_en_c = bus.ihit;
            end
            S_EXEC: begin
                case (cls)
                    C_BEQ: begin pc_en_c = 1'b1; pc_sel_c = bus.zero ? 2'd1 : 2'd0; end
                    C_BNE: begin pc_en_c = 1'b1; pc_sel_c = bus.zero ? 2'd0 : 2'd1; end
                    C_J:   begin pc_en_c = 1'b1; pc_sel_c = 2'd2; end
                    C_JAL: begin
                        pc_en_c  = 1'b1;
                        pc_sel_c = 2'd2;
                        reg_wr_c = 1'b1;
                        regdst_c = 2'd2;
                        wsel_c   = 2'd2;
                    end
                    C_JR:  begin pc_en_c = 1'b1; pc_sel_c = 2'd3; end
                    C_NOP: pc_en_c = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                dren_c  = (cls == C_LW);
                dwen_c  = (cls == C_SW);
                pc_en_c = (cls == C_SW) && bus.dhit;
            end
            S_WB: begin
                reg_wr_c = 1'b1;
                pc_en_c  = 1'b1;
                regdst_c = (cls == C_RALU) ? 2'd1 : 2'd0;
                wsel_c   = (cls == C_LW) ? 2'd1 : (cls == C_LUI) ? 2'd3 : 2'd0;
            end
            default: ;
        endcase
    end

    logic [CNT_W-1:0] cycle_cnt_c, instr_cnt_c;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    // Cycles until HALTED; retired instructions = PC updates + HALT decode
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALTED)
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (pc_en_c || (state_q == S_DECODE && cls == C_HALT))
                instr_cnt_q <= instr_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt_c = cycle_cnt_q;
    assign instr_cnt_c = instr_cnt_q;
`else
    assign cycle_cnt_c = '0;
    assign instr_cnt_c = '0;
`endif

    // Everything is held at 0 while reset is asserted
    assign bus.state       = RST ? 3'd0 : state_q;
    assign bus.iren        = iren_c   & ~RST;
    assign bus.ir_en       = ir_en_c  & ~RST;
    assign bus.dren        = dren_c   & ~RST;
    assign bus.dwen        = dwen_c   & ~RST;
    assign bus.reg_wr      = reg_wr_c & ~RST;
    assign bus.regdst      = RST ? 2'd0 : regdst_c;
    assign bus.wsel        = RST ? 2'd0 : wsel_c;
    assign bus.alu_op      = RST ? 4'd0 : alu_c;
    assign bus.alu_src_imm = src_c    & ~RST;
    assign bus.imm_ext     = RST ? 32'd0 : imm_c;
    assign bus.pc_en       = pc_en_c  & ~RST;
    assign bus.pc_sel      = RST ? 2'd0 : pc_sel_c;
    assign bus.halt        = halt_q   & ~RST;
    assign bus.fault       = fault_q  & ~RST;
    assign bus.cycle_cnt   = RST ? '0 : cycle_cnt_c;
    assign bus.instr_cnt   = RST ? '0 : instr_cnt_c;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle check of every control output,
// plus hand sequences for the watchdog and the HALT/perf-counter path.
module tb_multicycle_control;
    localparam int CNT_W = 32;

    localparam logic [31:0] ADDU = 32'h0022_1821;
    localparam logic [31:0] LW   = 32'h8C22_0004;
    localparam logic [31:0] SW   = 32'hAC22_0008;
    localparam logic [31:0] BEQ  = 32'h1000_0004;
    localparam logic [31:0] ORI  = 32'h3422_FFFF;
    localparam logic [31:0] ADDI = 32'h2022_FFFC;
    localparam logic [31:0] LUI  = 32'h3C02_1234;
    localparam logic [31:0] SLL  = 32'h0002_1080;
    localparam logic [31:0] JAL  = 32'h0C00_0010;
    localparam logic [31:0] JR   = 32'h03E0_0008;
    localparam logic [31:0] UNK  = 32'h7C00_0000;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    typedef struct packed {
        logic [2:0]  state;
        logic        iren, ir_en, dren, dwen, reg_wr;
        logic [1:0]  regdst, wsel;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic [31:0] imm_ext;
        logic        pc_en;
        logic [1:0]  pc_sel;
        logic        halt, fault;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        ihit, dhit, zero;
        outs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    function automatic outs_t O(input logic [2:0] st, input logic iren, input logic ir_en,
                                input logic dren, input logic dwen, input logic reg_wr,
                                input logic [1:0] regdst, input logic [1:0] wsel,
                                input logic [3:0] alu, input logic src, input logic [31:0] imm,
                                input logic pc_en, input logic [1:0] pc_sel,
                                input logic halt, input logic fault);
        outs_t o;
        o.state = st; o.iren = iren; o.ir_en = ir_en; o.dren = dren; o.dwen = dwen;
        o.reg_wr = reg_wr; o.regdst = regdst; o.wsel = wsel; o.alu_op = alu;
        o.alu_src_imm = src; o.imm_ext = imm; o.pc_en = pc_en; o.pc_sel = pc_sel;
        o.halt = halt; o.fault = fault;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.state = bus.state; o.iren = bus.iren; o.ir_en = bus.ir_en; o.dren = bus.dren;
        o.dwen = bus.dwen; o.reg_wr = bus.reg_wr; o.regdst = bus.regdst; o.wsel = bus.wsel;
        o.alu_op = bus.alu_op; o.alu_src_imm = bus.alu_src_imm; o.imm_ext = bus.imm_ext;
        o.pc_en = bus.pc_en; o.pc_sel = bus.pc_sel; o.halt = bus.halt; o.fault = bus.fault;
        return o;
    endfunction

    task automatic add(input logic r, input logic [31:0] ins, input logic ih,
                       input logic dh, input logic z, input outs_t e);
        vec_t v;
        v.rst = r; v.instr = ins; v.ihit = ih; v.dhit = dh; v.zero = z; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d iren=%b ir_en=%b dren=%b dwen=%b rw=%b rd=%0d ws=%0d alu=%0d src=%b imm=%h pe=%b ps=%0d h=%b f=%b, expected st=%0d iren=%b ir_en=%b dren=%b dwen=%b rw=%b rd=%0d ws=%0d alu=%0d src=%b imm=%h pe=%b ps=%0d h=%b f=%b",
                     name, act.state, act.iren, act.ir_en, act.dren, act.dwen, act.reg_wr,
                     act.regdst, act.wsel, act.alu_op, act.alu_src_imm, act.imm_ext, act.pc_en,
                     act.pc_sel, act.halt, act.fault, exp.state, exp.iren, exp.ir_en, exp.dren,
                     exp.dwen, exp.reg_wr, exp.regdst, exp.wsel, exp.alu_op, exp.alu_src_imm,
                     exp.imm_ext, exp.pc_en, exp.pc_sel, exp.halt, exp.fault);
        end
    endtask

    // Inputs are applied just after the rising edge; outputs sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.ihit = 1'b0; bus.dhit = 1'b0; bus.zero = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    outs_t Z;

    initial begin
        bus.instr = ADDU; bus.ihit = 1'b1; bus.dhit = 1'b0; bus.zero = 1'b0;
        Z = O(0,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0);

        // reset with ihit high: everything 0
        repeat (3) add(1, ADDU, 1, 0, 0, Z);
        // ADDU: F D E WB
        add(0, ADDU, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ADDU, 1, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ADDU, 0, 0, 0, O(2,0,0,0,0,0,0,0,2,0,32'h0,0,0,0,0));
        add(0, ADDU, 0, 0, 0, O(4,0,0,0,0,1,1,0,2,0,32'h0,1,0,0,0));
        // fetch stall, then LW with 3 dhit-low MEM cycles
        add(0, LW, 0, 0, 0, O(0,1,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, LW, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, LW, 0, 1, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, LW, 0, 0, 0, O(2,0,0,0,0,0,0,0,2,1,32'h4,0,0,0,0));
        repeat (3) add(0, LW, 0, 0, 0, O(3,0,0,1,0,0,0,0,2,1,32'h4,0,0,0,0));
        add(0, LW, 0, 1, 0, O(3,0,0,1,0,0,0,0,2,1,32'h4,0,0,0,0));
        add(0, LW, 0, 1, 0, O(4,0,0,0,0,1,0,1,2,1,32'h4,1,0,0,0));
        // BEQ taken, then not taken
        add(0, BEQ, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, BEQ, 0, 0, 1, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, BEQ, 0, 0, 1, O(2,0,0,0,0,0,0,0,3,0,32'h4,1,1,0,0));
        add(0, BEQ, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, BEQ, 0, 0, 1, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, BEQ, 0, 0, 0, O(2,0,0,0,0,0,0,0,3,0,32'h4,1,0,0,0));
        // SW with one wait
        add(0, SW, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, SW, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, SW, 0, 1, 0, O(2,0,0,0,0,0,0,0,2,1,32'h8,0,0,0,0));
        add(0, SW, 0, 0, 0, O(3,0,0,0,1,0,0,0,2,1,32'h8,0,0,0,0));
        add(0, SW, 0, 1, 0, O(3,0,0,0,1,0,0,0,2,1,32'h8,1,0,0,0));
        // ORI zero-extends
        add(0, ORI, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ORI, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ORI, 0, 0, 0, O(2,0,0,0,0,0,0,0,5,1,32'h0000_FFFF,0,0,0,0));
        add(0, ORI, 0, 0, 0, O(4,0,0,0,0,1,0,0,5,1,32'h0000_FFFF,1,0,0,0));
        // ADDI sign-extends
        add(0, ADDI, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ADDI, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ADDI, 0, 0, 0, O(2,0,0,0,0,0,0,0,2,1,32'hFFFF_FFFC,0,0,0,0));
        add(0, ADDI, 0, 0, 0, O(4,0,0,0,0,1,0,0,2,1,32'hFFFF_FFFC,1,0,0,0));
        // LUI writes {imm,16'h0}
        add(0, LUI, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, LUI, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, LUI, 0, 0, 0, O(2,0,0,0,0,0,0,0,0,0,32'h1234,0,0,0,0));
        add(0, LUI, 0, 0, 0, O(4,0,0,0,0,1,0,3,0,0,32'h1234,1,0,0,0));
        // SLL presents shamt
        add(0, SLL, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, SLL, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, SLL, 0, 0, 0, O(2,0,0,0,0,0,0,0,0,0,32'h2,0,0,0,0));
        add(0, SLL, 0, 0, 0, O(4,0,0,0,0,1,1,0,0,0,32'h2,1,0,0,0));
        // JAL, JR, unknown opcode
        add(0, JAL, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, JAL, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, JAL, 0, 0, 0, O(2,0,0,0,0,1,2,2,0,0,32'h0,1,2,0,0));
        add(0, JR, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, JR, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, JR, 0, 0, 0, O(2,0,0,0,0,0,0,0,0,0,32'h0,1,3,0,0));
        add(0, UNK, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, UNK, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, UNK, 0, 0, 0, O(2,0,0,0,0,0,0,0,0,0,32'h0,1,0,0,0));
        // reset landing in WB aborts the write and PC update
        add(0, ADDU, 1, 0, 0, O(0,1,1,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ADDU, 0, 0, 0, O(1,0,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
        add(0, ADDU, 0, 0, 0, O(2,0,0,0,0,0,0,0,2,0,32'h0,0,0,0,0));
        add(1, ADDU, 0, 0, 0, Z);
        add(0, ADDU, 0, 0, 0, O(0,1,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; bus.instr = vecs[i].instr; bus.ihit = vecs[i].ihit;
            bus.dhit = vecs[i].dhit; bus.zero = vecs[i].zero;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), sample(), vecs[i].exp);
            next_cycle();
        end

        // Watchdog: 4 no-hit FETCH cycles, then sticky fault until reset
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_outs($sformatf("wd_fetch%0d", c), sample(), O(0,1,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));
            next_cycle();
        end
        bus.ihit = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_outs($sformatf("wd_halted%0d", c), sample(), O(5,0,0,0,0,0,0,0,0,0,32'h0,0,0,1,1));
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        chk_outs("wd_in_reset", sample(), Z);
        next_cycle();
        rst = 1'b0; bus.ihit = 1'b0;
        @(negedge clk);
        chk_outs("wd_after_reset", sample(), O(0,1,0,0,0,0,0,0,0,0,32'h0,0,0,0,0));

        // ADDU, ORI, HALT with zero wait; HALTED must be reached in 10 cycles
        do_reset();
        bus.ihit = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.instr = (c < 4) ? ADDU : (c < 8) ? ORI : HALT;
            next_cycle();
        end
        @(negedge clk);
        chk("halt_state", 64'(bus.state), 64'd5);
        chk("halt_flag", 64'(bus.halt), 64'd1);
        chk("halt_nofault", 64'(bus.fault), 64'd0);
`ifdef MC_PERF_CNT_EN
        chk("cycle_cnt", 64'(bus.cycle_cnt), 64'd10);
        chk("instr_cnt", 64'(bus.instr_cnt), 64'd3);
        repeat (5) next_cycle();
        @(negedge clk);
        chk("cycle_cnt_frozen", 64'(bus.cycle_cnt), 64'd10);
        chk("instr_cnt_frozen", 64'(bus.instr_cnt), 64'd3);
`else
        chk("cycle_cnt_off", 64'(bus.cycle_cnt), 64'd0);
        chk("instr_cnt_off", 64'(bus.instr_cnt), 64'd0);
        repeat (5) next_cycle();
        @(negedge clk);
`endif
        chk("halt_held", 64'(bus.state), 64'd5);
        chk_outs("halted_outs", sample(), O(5,0,0,0,0,0,0,0,0,0,32'h0,0,0,1,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
